calc_arbiter: RTL
=================

Name: calc_arbiter

Overview:
- Sequential front-end that shares one CombCalc datapath instance between two requesters.
- Round-robin arbitration, valid/ready request handshake per requester, single registered response channel tagged with requester ID.
- Sits between requester logic and the combinational calculator.
- Ensures operands are stable for a full cycle and results are held until consumed.

Parameters:
W, 16, operand/result width in bits, passed to the CombCalc instance (W >= 4).

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: requester i's operation accepted this cycle (combinational, one-hot or zero)
req0_op  input  3  requester 0 opcode
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req1_op  input  3  requester 1 opcode
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
resp_valid  output  1  response registers hold a result
resp_ready  input  1  consumer accepts response
resp_id  output  1  requester that issued the response
resp_r  output  W  result
resp_ovf  output  1  overflow flag of result
busy  output  1  high whenever state != IDLE

Behaviour:
- Opcodes, all two's complement, mod 2^W:
  - 000: A+B
  - 001: A-B
  - 01x: |B|
  - 100: B+A
  - 101: B-A
  - 11x: |A|
- ovf on signed add/sub overflow.
- ovf on abs of the most-negative value (R = most-negative, ovf=1). The check is full-width, not a low-bit pattern.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if any req_valid, grant one requester. Assert req_ready[g] in that same cycle, latch g's op/a/b and g into op_q/a_q/b_q/id_q, update last_grant=g, go to EXEC. If no req_valid, stay in IDLE.
  - EXEC: CombCalc is driven only from op_q/a_q/b_q. Register its R/ovf into resp_r/resp_ovf, set resp_id=id_q and resp_valid=1, go to RESP.
  - RESP: hold all resp_* outputs stable. When resp_valid & resp_ready, clear resp_valid and go to IDLE. No request is accepted in RESP, including the handshake cycle.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- req_ready is 0 outside IDLE and 0 for the non-granted requester.
- Requester inputs are sampled only in the accept cycle. Changes afterward do not affect the in-flight operation.
- Latency: accept in cycle N, resp_valid high from cycle N+2. Back-to-back throughput is 1 op / 3 cycles with resp_ready tied high.
- Reset, asynchronous, any state:
  - state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_r=0, resp_ovf=0, busy=0, last_grant=1, operand registers=0.
  - An in-flight op is discarded with no response. A request still valid after reset deasserts is re-arbitrated normally.
- req_valid may drop without being accepted; no state is retained for it.

Optional Feature:
- CALC_OVF_COUNT_EN defined:
  - Adds output ovf_count [7:0].
  - Increments on each response handshake (resp_valid & resp_ready) with resp_ovf=1.
  - Saturates at 0xFF and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Req0 only, op 000, A=0x0005, B=0x0003, resp_ready=1 -> req_ready=01 at cycle N; resp_valid at N+2 with resp_r=0x0008, resp_id=0, resp_ovf=0.
- Both valid continuously, req0 op 001 A=0x0010 B=0x0001, req1 op 101 A=0x0001 B=0x0010, resp_ready=1 -> grants alternate 0,1,0,1; every response resp_r=0x000F; resp_id alternates 0,1.
- Overflow cases -> responses with the listed values:
  - op 000, A=0x7FFF, B=0x0001 -> resp_r=0x8000, ovf=1.
  - op 110, A=0x8000 -> resp_r=0x8000, ovf=1.
  - op 010, B=0xFFFD -> resp_r=0x0003, ovf=0.
  - op 111, A=0x0007 -> resp_r=0x0007, ovf=0.
- Backpressure: resp_ready=0 for 5 cycles with req1 valid -> resp_* stable, busy=1, req_ready=00 throughout; req1 is granted the cycle after the resp_ready=1 handshake.
- Reset asserted during EXEC with req0 held valid -> all outputs 0 immediately; after release req0 is re-accepted and answered once, with no response for the discarded op.
- With CALC_OVF_COUNT_EN: 300 overflowing ops (A=0x7FFF, B=0x0001) -> ovf_count=0xFF; a non-overflowing op leaves it at 0xFF.

Source files
------------

// File: rtl/calc_arbiter.sv
// calc_arbiter: shares one comb_calc datapath between two requesters with
// round-robin arbitration and a single registered, ID-tagged response channel.
// Optional build macro: CALC_OVF_COUNT_EN adds an 8-bit saturating counter of
// overflowing responses (output ovf_count).

// comb_calc: purely combinational two's-complement add/sub/abs unit.
module comb_calc #(
  parameter int W = 16
) (
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r,
  output logic         o_ovf
);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_abs_src;

  // op[2] swaps operand order for add/sub and selects A (vs B) for abs
  always_comb begin
    w_x       = i_op[2] ? i_b : i_a;
    w_y       = i_op[2] ? i_a : i_b;
    w_abs_src = i_op[2] ? i_a : i_b;
    w_sum     = w_x + w_y;
    w_diff    = w_x - w_y;
    o_r       = '0;
    o_ovf     = 1'b0;
    if (i_op[1]) begin
      // abs: negating the most-negative value wraps back to itself
      o_r   = w_abs_src[W-1] ? (~w_abs_src + 1'b1) : w_abs_src;
      o_ovf = (w_abs_src == MOST_NEG);
    end else if (i_op[0]) begin
      o_r   = w_diff;
      o_ovf = (w_x[W-1] != w_y[W-1]) && (w_diff[W-1] != w_x[W-1]);
    end else begin
      o_r   = w_sum;
      o_ovf = (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);
    end
  end
endmodule

module calc_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_r,
  output logic         resp_ovf,
`ifdef CALC_OVF_COUNT_EN
  output logic [7:0]   ovf_count,
`endif
  output logic         busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]   r_state;
  logic         r_last_grant;
  logic [2:0]   r_op_q;
  logic [W-1:0] r_a_q;
  logic [W-1:0] r_b_q;
  logic         r_id_q;
  logic         r_resp_valid;
  logic         r_resp_id;
  logic [W-1:0] r_resp_r;
  logic         r_resp_ovf;

  logic         w_grant_id;
  logic         w_accept;
  logic [W-1:0] w_calc_r;
  logic         w_calc_ovf;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  // Reset is folded in so req_ready is low while reset is held.
  always_comb begin
    if (req_valid == 2'b11) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = req_valid[1];
    end
    w_accept  = (r_state == S_IDLE) && (|req_valid) && !reset;
    req_ready = w_accept ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
  end

  // The datapath sees only the latched operands, never the live requester inputs
  comb_calc #(.W(W)) u_calc (
    .i_op  (r_op_q),
    .i_a   (r_a_q),
    .i_b   (r_b_q),
    .o_r   (w_calc_r),
    .o_ovf (w_calc_ovf)
  );

  // Control FSM: accept in IDLE, register the result in EXEC, hold it in RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op_q       <= '0;
      r_a_q        <= '0;
      r_b_q        <= '0;
      r_id_q       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_r     <= '0;
      r_resp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_q       <= w_grant_id ? req1_op : req0_op;
            r_a_q        <= w_grant_id ? req1_a  : req0_a;
            r_b_q        <= w_grant_id ? req1_b  : req0_b;
            r_id_q       <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_r     <= w_calc_r;
          r_resp_ovf   <= w_calc_ovf;
          r_resp_id    <= r_id_q;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_OVF_COUNT_EN
  logic [7:0] r_ovf_count;

  // Count consumed overflowing responses, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_count <= 8'd0;
    end else if (r_resp_valid && resp_ready && r_resp_ovf && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_r     = r_resp_r;
  assign resp_ovf   = r_resp_ovf;
  assign busy       = (r_state != S_IDLE);
endmodule
